// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, mux selects, opcodes, ALU ops.
// ILLEGAL_TRAP_EN makes TRAP raise the illegal flag; by default TRAP is a one-cycle no-op.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP
  } state_t;

  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RD1 = 2'b10;
  localparam logic [1:0] SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10;
  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT, ALUOP_PASSB} aluop_t;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_PASSB = 4'd10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    aluop_t     alu_op;
    logic       illegal;
  } ctrl_t;

  // Moore output word for a state; anything not set stays 0.
  function automatic ctrl_t state_ctrl(state_t s, logic is_store);
    ctrl_t c;
    c = '0;
    c.alu_op = ALUOP_FUNCT;
    case (s)
      FETCH:    begin c.mem_read = 1'b1; c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALURESULT; c.alu_op = ALUOP_ADD; end
      DECODE:   begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; c.imm_src = IMM_B; c.alu_op = ALUOP_ADD; end
      MEMADR:   begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_IMM; c.imm_src = is_store ? IMM_S : IMM_I; c.alu_op = ALUOP_ADD; end
      MEMREAD:  begin c.adr_src = 1'b1; c.mem_read = 1'b1; end
      MEMWB:    begin c.result_src = RES_DATA; c.reg_write = 1'b1; end
      MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      EXECR:    begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_RD2; end
      EXECI:    begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_IMM; c.imm_src = IMM_I; end
      ALUWB:    begin c.result_src = RES_ALUOUT; c.reg_write = 1'b1; end
      BRANCH:   begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_RD2; c.result_src = RES_ALUOUT; c.alu_op = ALUOP_SUB; end
      JAL:      begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALUOUT; c.imm_src = IMM_J; c.alu_op = ALUOP_ADD; end
      JALR:     begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_IMM; c.imm_src = IMM_I; c.alu_op = ALUOP_ADD; end
      LUI:      begin c.alu_src_b = SRCB_IMM; c.imm_src = IMM_U; c.alu_op = ALUOP_PASSB; end
      AUIPC:    begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; c.imm_src = IMM_U; c.alu_op = ALUOP_ADD; end
`ifdef ILLEGAL_TRAP_EN
      TRAP:     c.illegal = 1'b1;
`endif
      default:  ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction, handshake and datapath-control bundle between controller (master) and datapath (slave).
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       branch_cond;
  logic       mem_ready;
  logic       pc_write, ir_write, reg_write, mem_write, mem_read, adr_src;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic       illegal;

  modport master (
    input  op, funct3, funct7b5, branch_cond, mem_ready,
    output pc_write, ir_write, reg_write, mem_write, mem_read, adr_src,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal
  );

  modport slave (
    output op, funct3, funct7b5, branch_cond, mem_ready,
    input  pc_write, ir_write, reg_write, mem_write, mem_read, adr_src,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal
  );
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from the FSM's ALU op class and the instruction fields.
module alu_decoder
  import ctrl_pkg::*;
(
  input  aluop_t     alu_op,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:   alu_control = ALU_ADD;
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_PASSB: alu_control = ALU_PASSB;
      default: begin
        case (funct3)
          // bit 30 is an immediate bit for addi, so only R-type may pick SUB
          3'b000:  alu_control = (op == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V main controller: Moore FSM with registered outputs; pc_write/ir_write follow handshakes.
// Define ILLEGAL_TRAP_EN to make unknown opcodes park in TRAP with illegal=1 until reset.
module multicycle_controller
  import ctrl_pkg::*;
(
  input logic              clk,
  input logic              reset,
  multicycle_controller_if.master bus
);

  state_t state, state_nxt;
  ctrl_t  ctl;
  logic   started;

  always_comb begin
    state_nxt = FETCH;
    if (started) begin
      case (state)
        FETCH:    state_nxt = bus.mem_ready ? DECODE : FETCH;
        DECODE: begin
          case (bus.op)
            OP_LOAD, OP_STORE: state_nxt = MEMADR;
            OP_RTYPE:          state_nxt = EXECR;
            OP_ITYPE:          state_nxt = EXECI;
            OP_BRANCH:         state_nxt = BRANCH;
            OP_JAL:            state_nxt = JAL;
            OP_JALR:           state_nxt = JALR;
            OP_LUI:            state_nxt = LUI;
            OP_AUIPC:          state_nxt = AUIPC;
            default:           state_nxt = TRAP;
          endcase
        end
        MEMADR:   state_nxt = (bus.op == OP_STORE) ? MEMWRITE : MEMREAD;
        MEMREAD:  state_nxt = bus.mem_ready ? MEMWB : MEMREAD;
        MEMWRITE: state_nxt = bus.mem_ready ? FETCH : MEMWRITE;
        EXECR, EXECI, JAL, JALR, LUI, AUIPC: state_nxt = ALUWB;
`ifdef ILLEGAL_TRAP_EN
        TRAP:     state_nxt = TRAP;
`endif
        default:  state_nxt = FETCH;
      endcase
    end
  end

  // started holds the FSM and all outputs quiet for the first cycle after reset release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      ctl     <= '0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      state   <= state_nxt;
      ctl     <= state_ctrl(state_nxt, bus.op == OP_STORE);
    end
  end

  assign bus.ir_write = started && (state == FETCH) && bus.mem_ready;
  assign bus.pc_write = started && (((state == FETCH) && bus.mem_ready) ||
                                    ((state == BRANCH) && bus.branch_cond) ||
                                    (state == JAL) || (state == JALR));

  assign bus.reg_write  = ctl.reg_write;
  assign bus.mem_write  = ctl.mem_write;
  assign bus.mem_read   = ctl.mem_read;
  assign bus.adr_src    = ctl.adr_src;
  assign bus.result_src = ctl.result_src;
  assign bus.alu_src_a  = ctl.alu_src_a;
  assign bus.alu_src_b  = ctl.alu_src_b;
  assign bus.imm_src    = ctl.imm_src;
  assign bus.illegal    = ctl.illegal;

  alu_decoder u_alu_decoder (
    .alu_op      (ctl.alu_op),
    .op          (bus.op),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .alu_control (bus.alu_control)
  );

endmodule
